// File: rtl/program_loader_if.sv
// ============================================================================
// Module  : program_loader_if
// Brief   : Host stream, memory port and core-control bundle for program_loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface program_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_run;
  logic              cpu_halted;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [DATA_W-1:0] checksum;

  // master: host + memory + core side; slave: the loader itself
  modport master (
    output start, base_addr, word_count, in_valid, in_data, mem_rdata, cpu_halted,
    input  in_ready, mem_we, mem_re, mem_addr, mem_wdata, cpu_run, busy, done,
           error, err_code, checksum
  );

  modport slave (
    input  start, base_addr, word_count, in_valid, in_data, mem_rdata, cpu_halted,
    output in_ready, mem_we, mem_re, mem_addr, mem_wdata, cpu_run, busy, done,
           error, err_code, checksum
  );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module  : program_loader
// Brief   : Streams host words into memory, optionally read-verifies them,
//           then runs the core until HALT or timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int MEM_DEPTH   = 1024,
  parameter int VERIFY_EN   = 1,
  parameter int RUN_TIMEOUT = 4096
) (
  input  logic             clk1,
  input  logic             rst,
  program_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] c_DEPTH      = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [31:0]     c_RUN_LAST   = 32'(RUN_TIMEOUT - 1);
  localparam state_t          c_AFTER_LOAD = (VERIFY_EN != 0) ? S_VERIFY : S_RUN;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base, r_wr_off, r_rd_addr, r_mem_addr;
  logic [ADDR_W:0]   r_count, r_remaining, r_rd_left;
  logic              r_mem_we, r_mem_re, r_rd_valid, r_done, r_error;
  logic [DATA_W-1:0] r_mem_wdata, r_checksum, r_vsum;
  logic [1:0]        r_err_code;
  logic [31:0]       r_run_cnt;

  logic              w_start_ok, w_in_ready, w_xfer, w_verify_done, w_timeout;
  logic              w_done_set, w_error_set;
  logic [1:0]        w_err_code;
  logic [ADDR_W:0]   w_end_addr;

  // count alone is bounded too, so the ADDR_W+1-bit end-address sum cannot wrap
  assign w_end_addr    = {1'b0, bus.base_addr} + bus.word_count;
  assign w_start_ok    = (bus.word_count != '0) && (bus.word_count <= c_DEPTH) &&
                         (w_end_addr <= c_DEPTH);
  assign w_in_ready    = (r_state == S_LOAD) && (r_remaining != '0);
  assign w_xfer        = bus.in_valid && w_in_ready;
  assign w_verify_done = (r_rd_left == '0) && !r_mem_re && !r_rd_valid;
  assign w_timeout     = (RUN_TIMEOUT != 0) && (r_run_cnt == c_RUN_LAST);

  always_ff @(posedge clk1) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    w_error_set = 1'b0;
    w_err_code  = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_start_ok) begin
            w_state_nxt = S_LOAD;
          end else begin
            w_error_set = 1'b1;
            w_err_code  = 2'b01;
          end
        end
      end
      S_LOAD: begin
        // leave one cycle after the last transfer so its write never overlaps a read
        if (r_remaining == '0) w_state_nxt = c_AFTER_LOAD;
      end
      S_VERIFY: begin
        if (w_verify_done) begin
          if (r_vsum == r_checksum) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_IDLE;
            w_error_set = 1'b1;
            w_err_code  = 2'b10;
          end
        end
      end
      S_RUN: begin
        if (bus.cpu_halted) begin
          w_state_nxt = S_IDLE;
          w_done_set  = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_error_set = 1'b1;
          w_err_code  = 2'b11;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_base      <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_wr_off    <= '0;
      r_rd_addr   <= '0;
      r_rd_left   <= '0;
      r_rd_valid  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_checksum  <= '0;
      r_vsum      <= '0;
      r_err_code  <= 2'b00;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_run_cnt   <= '0;
    end else begin
      r_mem_we   <= 1'b0;
      r_mem_re   <= 1'b0;
      r_rd_valid <= r_mem_re;
      r_done     <= w_done_set;
      r_error    <= w_error_set;
      r_run_cnt  <= (r_state == S_RUN) ? r_run_cnt + 32'd1 : 32'd0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_base      <= bus.base_addr;
            r_count     <= bus.word_count;
            r_remaining <= bus.word_count;
            r_wr_off    <= '0;
            r_checksum  <= '0;
            r_err_code  <= 2'b00;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_base + r_wr_off;
            r_mem_wdata <= bus.in_data;
            r_checksum  <= r_checksum + bus.in_data;
            r_wr_off    <= r_wr_off + 1'b1;
            r_remaining <= r_remaining - 1'b1;
          end
          if (r_remaining == '0) begin
            r_rd_addr <= r_base;
            r_rd_left <= r_count;
            r_vsum    <= '0;
          end
        end
        S_VERIFY: begin
          if (r_rd_left != '0) begin
            r_mem_re   <= 1'b1;
            r_mem_addr <= r_rd_addr;
            r_rd_addr  <= r_rd_addr + 1'b1;
            r_rd_left  <= r_rd_left - 1'b1;
          end
          if (r_rd_valid) r_vsum <= r_vsum + bus.mem_rdata;
        end
        default: ;
      endcase
      if (w_error_set) r_err_code <= w_err_code;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_run   = (r_state == S_RUN);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.error     = r_error;
  assign bus.err_code  = r_err_code;
  assign bus.checksum  = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module  : tb_program_loader
// Brief   : Directed scoreboard bench for program_loader with a memory model
//           and a stub core that raises HALT after a programmable run length.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk1 = 1'b0;
  logic rst;
  always #5 clk1 = ~clk1;

  program_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  program_loader #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(1024), .VERIFY_EN(1), .RUN_TIMEOUT(16)
  ) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  logic [DW-1:0] mem [0:1023];
  logic          corrupt;
  int            n_writes, n_reads, run_cycles, halt_at;
  logic [AW-1:0] rd_base;

  logic [DW-1:0] prog [8] = '{32'h28010078, 32'h0ce77800, 32'h20220000, 32'h0ce77800,
                              32'h2842002d, 32'h0ce77800, 32'h24220001, 32'hfc000000};
  logic [DW-1:0] words2 [4] = '{32'hdeadbeef, 32'h12345678, 32'h0badf00d, 32'h00000011};

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: read returns data next cycle, optional corruption of address 3
  always @(posedge clk1) begin
    if (bus.mem_re)
      bus.mem_rdata <= (corrupt && bus.mem_addr == 10'd3) ? ~mem[bus.mem_addr] : mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
  end

  // Stub core plus write/read monitors; writes are popped from the scoreboard
  always @(negedge clk1) begin
    if (bus.cpu_run) begin
      run_cycles++;
      if (halt_at != 0 && run_cycles >= halt_at) bus.cpu_halted = 1'b1;
    end else begin
      bus.cpu_halted = 1'b0;
    end
    if (bus.mem_we) begin
      n_writes++;
      check("wr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
      if (exp_addr_q.size() != 0) begin
        check("wr_addr", 32'(bus.mem_addr), 32'(exp_addr_q.pop_front()));
        check("wr_data", bus.mem_wdata, exp_data_q.pop_front());
      end
    end
    if (bus.mem_re) begin
      check("rd_addr", 32'(bus.mem_addr), 32'(rd_base) + 32'(n_reads));
      check("we_re_excl", 32'(bus.mem_we), 32'd0);
      n_reads++;
    end
  end

  task automatic clear_stats(input int halt);
    n_writes   = 0;
    n_reads    = 0;
    run_cycles = 0;
    halt_at    = halt;
  endtask

  task automatic do_start(input int base, input int cnt);
    @(negedge clk1);
    bus.start      = 1'b1;
    bus.base_addr  = AW'(base);
    bus.word_count = (AW+1)'(cnt);
    rd_base        = AW'(base);
    @(negedge clk1);
    bus.start      = 1'b0;
  endtask

  task automatic send(input int base, input int n, input bit toggle, input bit use2,
                      output logic [DW-1:0] sum);
    int i   = 0;
    int cyc = 0;
    sum = '0;
    while (i < n && cyc < 100) begin
      bus.in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.in_data  = use2 ? words2[i] : prog[i];
      if (bus.in_valid && bus.in_ready) begin
        exp_addr_q.push_back(AW'(base + i));
        exp_data_q.push_back(bus.in_data);
        sum = sum + bus.in_data;
        i++;
      end
      cyc++;
      @(negedge clk1);
    end
    bus.in_valid = 1'b0;
    check("send_count", 32'(i), 32'(n));
  endtask

  task automatic wait_end(output bit got_done, output bit got_err, output logic [1:0] code);
    for (int c = 0; c < 200; c++) begin
      if (bus.done || bus.error) break;
      @(negedge clk1);
    end
    got_done = bus.done;
    got_err  = bus.error;
    code     = bus.err_code;
    check("end_seen", 32'(got_done | got_err), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] sum1, sum;
    bit            gd, ge;
    logic [1:0]    code;

    for (int a = 0; a < 1024; a++) mem[a] = '0;
    mem[120]       = 32'd17;
    corrupt        = 1'b0;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.cpu_halted = 1'b0;
    rd_base        = '0;
    clear_stats(0);
    rst = 1'b1;
    repeat (3) @(negedge clk1);
    rst = 1'b0;
    @(negedge clk1);

    // Reset state
    check("rst_busy",     32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_we_re",    32'({bus.mem_we, bus.mem_re}), 32'd0);
    check("rst_run",      32'(bus.cpu_run), 32'd0);
    check("rst_pulses",   32'({bus.done, bus.error}), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);
    check("rst_checksum", bus.checksum, 32'd0);
    check("rst_addr",     32'(bus.mem_addr), 32'd0);

    // 1: eight-word load at base 0, verify passes, core halts after 5 cycles
    clear_stats(5);
    do_start(0, 8);
    send(0, 8, 1'b0, 1'b0, sum1);
    wait_end(gd, ge, code);
    check("t1_done",     32'(gd), 32'd1);
    check("t1_code",     32'(code), 32'd0);
    check("t1_checksum", bus.checksum, sum1);
    check("t1_writes",   32'(n_writes), 32'd8);
    check("t1_reads",    32'(n_reads), 32'd8);
    check("t1_run",      32'(run_cycles), 32'd5);
    for (int a = 0; a < 8; a++) check("t1_mem", mem[a], prog[a]);
    check("t1_mem120",   mem[120], 32'd17);

    // 2: same load, in_valid toggling
    clear_stats(5);
    do_start(0, 8);
    send(0, 8, 1'b1, 1'b0, sum);
    wait_end(gd, ge, code);
    check("t2_done",     32'(gd), 32'd1);
    check("t2_writes",   32'(n_writes), 32'd8);
    check("t2_checksum", bus.checksum, sum1);

    // 3: range error
    clear_stats(5);
    do_start(1020, 8);
    wait_end(gd, ge, code);
    check("t3_error",  32'(ge), 32'd1);
    check("t3_code",   32'(code), 32'd1);
    repeat (3) @(negedge clk1);
    check("t3_nowrite", 32'(n_writes), 32'd0);
    check("t3_idle",    32'(bus.busy), 32'd0);
    check("t3_hold",    32'(bus.err_code), 32'd1);

    // 4: readback corruption at address 3
    clear_stats(5);
    corrupt = 1'b1;
    do_start(0, 8);
    send(0, 8, 1'b0, 1'b0, sum);
    wait_end(gd, ge, code);
    check("t4_error",    32'(ge), 32'd1);
    check("t4_code",     32'(code), 32'd2);
    check("t4_norun",    32'(run_cycles), 32'd0);
    check("t4_checksum", bus.checksum, sum);
    corrupt = 1'b0;

    // 5: core never halts -> timeout after 16 run cycles
    clear_stats(0);
    do_start(0, 8);
    send(0, 8, 1'b0, 1'b0, sum);
    wait_end(gd, ge, code);
    check("t5_error", 32'(ge), 32'd1);
    check("t5_code",  32'(code), 32'd3);
    check("t5_run",   32'(run_cycles), 32'd16);
    check("t5_runlo", 32'(bus.cpu_run), 32'd0);

    // 6: reset after 3 transfers, then a fresh load elsewhere
    clear_stats(3);
    do_start(100, 8);
    send(100, 3, 1'b0, 1'b0, sum);
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    @(negedge clk1);
    check("t6_pre_writes", 32'(n_writes), 32'd3);
    check("t6_q_empty",    32'(exp_addr_q.size()), 32'd0);
    check("t6_rst_we",     32'(bus.mem_we), 32'd0);
    check("t6_rst_busy",   32'(bus.busy), 32'd0);
    clear_stats(3);
    do_start(200, 4);
    send(200, 4, 1'b0, 1'b1, sum);
    wait_end(gd, ge, code);
    check("t6_done",     32'(gd), 32'd1);
    check("t6_checksum", bus.checksum, sum);
    check("t6_writes",   32'(n_writes), 32'd4);
    check("t6_mem200",   mem[200], words2[0]);

    @(negedge clk1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
